// File: rtl/ac_pkg.sv
// Shared AUTOCONFIG constants: register offsets, base-register codes, sequencer states.
package ac_pkg;

   localparam logic [7:0] AC_EC_BASE_Z3 = 8'h44;
   localparam logic [7:0] AC_EC_BASE_HI = 8'h48;
   localparam logic [7:0] AC_EC_BASE_LO = 8'h4A;
   localparam logic [7:0] AC_EC_SHUTUP  = 8'h4C;

   typedef enum logic [1:0] {
      BREG_Z3  = 2'd0,
      BREG_HI  = 2'd1,
      BREG_LO  = 2'd2,
      BREG_RSV = 2'd3
   } base_reg_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      ACK  = 2'd3
   } ac_state_e;

endpackage

// File: rtl/ac_chain_sequencer.sv
// Walks the on-board AUTOCONFIG chain one device at a time, then releases CONFIG_OUTn.
// Reads ack two edges after TSn, writes three; no backpressure, TSn outside IDLE is ignored.
module ac_chain_sequencer
   import ac_pkg::*;
#(
   parameter int                 NUM_DEV = 2,
   parameter logic [NUM_DEV-1:0] DEV_Z3  = 2'b10,
   parameter int                 IDX_W   = 2
) (
   input  logic                   CLK40,
   input  logic                   RESET,
   input  logic                   AUTOCONFIG_SPACE,
   input  logic                   TSn,
   input  logic                   RnW,
   input  logic [6:0]             A,
   input  logic [3:0]             D_IN,
   output logic [3:0]             D_OUT,
   output logic                   AC_TACK,
   output logic [7:0]             AC_AD,
   input  logic [4*NUM_DEV-1:0]   DEV_NIBBLE,
   output logic [IDX_W-1:0]       ACTIVE_DEV,
   output logic [NUM_DEV-1:0]     BASE_WE,
   output logic [1:0]             BASE_REG,
   output logic [3:0]             BASE_DATA,
   output logic [NUM_DEV-1:0]     DEV_CONFIGURED,
   output logic                   CONFIGURED,
   output logic                   CONFIG_OUTn
);

   ac_state_e           state;
   logic                commit_q;
   logic [3:0]          read_latch;

   logic [3:0]          act_nib;
   logic [NUM_DEV-1:0]  act_onehot;
   logic                act_z3;
   logic                wr_strobe;
   logic                wr_commit;
   base_reg_e           wr_reg;
   logic [IDX_W-1:0]    next_idx;

   // ACTIVE_DEV reaches NUM_DEV once done; that value selects no device.
   always_comb begin
      act_nib    = 4'h0;
      act_onehot = '0;
      act_z3     = 1'b0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (ACTIVE_DEV == IDX_W'(i)) begin
            act_nib       = DEV_NIBBLE[4*i +: 4];
            act_onehot[i] = 1'b1;
            act_z3        = DEV_Z3[i];
         end
      end
   end

   always_comb begin
      wr_strobe = 1'b0;
      wr_commit = 1'b0;
      wr_reg    = BREG_Z3;
      case (AC_AD)
         AC_EC_BASE_LO: begin
            wr_strobe = 1'b1;
            wr_reg    = BREG_LO;
         end
         AC_EC_BASE_HI: begin
            wr_strobe = 1'b1;
            wr_reg    = BREG_HI;
            wr_commit = !act_z3;
         end
         AC_EC_BASE_Z3: begin
            wr_strobe = 1'b1;
            wr_commit = act_z3;
         end
         AC_EC_SHUTUP: wr_commit = 1'b1;
         default: ;
      endcase
   end

   assign next_idx = ACTIVE_DEV + IDX_W'(1);
   assign D_OUT    = CONFIGURED ? 4'hF : read_latch;

   always_ff @(posedge CLK40) begin
      if (RESET) begin
         state          <= IDLE;
         commit_q       <= 1'b0;
         read_latch     <= 4'h0;
         AC_TACK        <= 1'b0;
         AC_AD          <= 8'h00;
         ACTIVE_DEV     <= '0;
         BASE_WE        <= '0;
         BASE_REG       <= 2'd0;
         BASE_DATA      <= 4'h0;
         DEV_CONFIGURED <= '0;
         CONFIGURED     <= 1'b0;
         CONFIG_OUTn    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               AC_TACK <= 1'b0;
               BASE_WE <= '0;
               if (!CONFIGURED && AUTOCONFIG_SPACE && !TSn) begin
                  AC_AD <= {A, 1'b0};
                  state <= RnW ? RD : WR;
               end
            end
            RD: begin
               read_latch <= act_nib;
               AC_TACK    <= 1'b1;
               state      <= IDLE;
            end
            WR: begin
               BASE_DATA <= D_IN;
               if (wr_strobe) begin
                  BASE_WE  <= act_onehot;
                  BASE_REG <= wr_reg;
               end
               commit_q <= wr_commit;
               state    <= ACK;
            end
            ACK: begin
               AC_TACK <= 1'b1;
               BASE_WE <= '0;
               if (commit_q) begin
                  DEV_CONFIGURED <= DEV_CONFIGURED | act_onehot;
                  ACTIVE_DEV     <= next_idx;
                  if (next_idx == IDX_W'(NUM_DEV)) begin
                     CONFIGURED  <= 1'b1;
                     CONFIG_OUTn <= 1'b0;
                  end
               end
               commit_q <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ac_chain_sequencer.sv
// Bench for ac_chain_sequencer: directed chain walk plus randomized transactions against a cycle-scheduled model.
module tb_ac_chain_sequencer;

   localparam int       NUM_DEV = 2;
   localparam bit [1:0] Z3      = 2'b10;

   logic       CLK40 = 1'b0;
   logic       RESET = 1'b1;
   logic       AUTOCONFIG_SPACE = 1'b0;
   logic       TSn = 1'b1;
   logic       RnW = 1'b1;
   logic [6:0] A = '0;
   logic [3:0] D_IN = '0;
   logic [3:0] D_OUT;
   logic       AC_TACK;
   logic [7:0] AC_AD;
   logic [7:0] DEV_NIBBLE = '0;
   logic [1:0] ACTIVE_DEV;
   logic [1:0] BASE_WE;
   logic [1:0] BASE_REG;
   logic [3:0] BASE_DATA;
   logic [1:0] DEV_CONFIGURED;
   logic       CONFIGURED;
   logic       CONFIG_OUTn;

   ac_chain_sequencer #(.NUM_DEV(NUM_DEV), .DEV_Z3(Z3), .IDX_W(2)) dut (
      .CLK40(CLK40), .RESET(RESET), .AUTOCONFIG_SPACE(AUTOCONFIG_SPACE),
      .TSn(TSn), .RnW(RnW), .A(A), .D_IN(D_IN), .D_OUT(D_OUT),
      .AC_TACK(AC_TACK), .AC_AD(AC_AD), .DEV_NIBBLE(DEV_NIBBLE),
      .ACTIVE_DEV(ACTIVE_DEV), .BASE_WE(BASE_WE), .BASE_REG(BASE_REG),
      .BASE_DATA(BASE_DATA), .DEV_CONFIGURED(DEV_CONFIGURED),
      .CONFIGURED(CONFIGURED), .CONFIG_OUTn(CONFIG_OUTn)
   );

   always #5 CLK40 = ~CLK40;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit started = 0;

   // Model: architectural state plus events scheduled for absolute edge numbers.
   int       m_active;
   bit [1:0] m_devcfg;
   bit       m_cfg;
   bit [3:0] m_latch, m_data;
   bit [1:0] m_reg;
   bit       e_tack;
   bit [1:0] e_we;
   bit       sch_tack[int];
   bit [1:0] sch_we[int];
   bit [1:0] sch_reg[int];
   bit [3:0] sch_data[int];
   bit [3:0] sch_latch[int];
   bit       sch_commit[int];

   int       n_tack = 0;
   bit [1:0] seen_we;
   bit [1:0] seen_reg;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge CLK40) begin
      cyc++;
      if (RESET) begin
         started  = 1;
         m_active = 0; m_devcfg = 0; m_cfg = 0;
         m_latch  = 0; m_data = 0; m_reg = 0;
         e_tack   = 0; e_we = 0;
         sch_tack.delete(); sch_we.delete(); sch_reg.delete();
         sch_data.delete(); sch_latch.delete(); sch_commit.delete();
      end else begin
         e_tack = sch_tack.exists(cyc);
         e_we   = sch_we.exists(cyc) ? sch_we[cyc] : 2'b00;
         if (sch_reg.exists(cyc))   m_reg   = sch_reg[cyc];
         if (sch_data.exists(cyc))  m_data  = sch_data[cyc];
         if (sch_latch.exists(cyc)) m_latch = sch_latch[cyc];
         if (sch_commit.exists(cyc)) begin
            m_devcfg[m_active] = 1'b1;
            m_active++;
            if (m_active == NUM_DEV) m_cfg = 1'b1;
         end
      end
   end

   always @(negedge CLK40) begin
      if (started) begin
         chk("AC_TACK", AC_TACK, e_tack);
         chk("BASE_WE", BASE_WE, e_we);
         if (e_we != 0) chk("BASE_REG", BASE_REG, m_reg);
         chk("BASE_DATA", BASE_DATA, m_data);
         chk("ACTIVE_DEV", ACTIVE_DEV, m_active);
         chk("DEV_CONFIGURED", DEV_CONFIGURED, m_devcfg);
         chk("CONFIGURED", CONFIGURED, m_cfg);
         chk("CONFIG_OUTn", CONFIG_OUTn, !m_cfg);
         chk("D_OUT", D_OUT, m_cfg ? 4'hF : m_latch);
         if (AC_TACK === 1'b1) n_tack++;
         if (BASE_WE !== 2'b00) begin
            seen_we  = BASE_WE;
            seen_reg = BASE_REG;
         end
      end
   end

   // Called just after an edge; TSn is sampled at the next edge N.
   task automatic issue(input bit rnw, input bit [7:0] off, input bit [3:0] d,
                        input bit [7:0] nib, input bit space, input bit want_rst,
                        input bit glitch, input int gap);
      int n, len, rst_at;
      bit [1:0] we, rg;
      bit commit;
      n = cyc + 1;
      len = 1;
      AUTOCONFIG_SPACE = space; TSn = 0; RnW = rnw; A = off[7:1]; D_IN = d; DEV_NIBBLE = nib;
      if (space && !m_cfg) begin
         if (rnw) begin
            len = 2;
            sch_tack[n+1]  = 1;
            sch_latch[n+1] = 4'((nib >> (4*m_active)) & 8'h0F);
         end else begin
            len = 3;
            we = 0; rg = 0; commit = 0;
            case (off)
               8'h4A: begin we = 2'(1 << m_active); rg = 2; end
               8'h48: begin we = 2'(1 << m_active); rg = 1; commit = !Z3[m_active]; end
               8'h44: begin we = 2'(1 << m_active); rg = 0; commit = Z3[m_active]; end
               8'h4C: commit = 1;
               default: ;
            endcase
            sch_data[n+1] = d;
            if (we != 0) begin sch_we[n+1] = we; sch_reg[n+1] = rg; end
            if (commit) sch_commit[n+2] = 1;
            sch_tack[n+2] = 1;
         end
      end
      rst_at = (want_rst && len > 1) ? $urandom_range(1, len-1) : 0;
      @(posedge CLK40); #1;
      for (int i = 1; i < len; i++) begin
         TSn   = (glitch && rst_at == 0) ? 1'b0 : 1'b1;
         RESET = (rst_at == i);
         @(posedge CLK40); #1;
      end
      TSn = 1; RESET = 0;
      for (int i = 0; i < gap; i++) begin @(posedge CLK40); #1; end
   endtask

   task automatic do_reset();
      RESET = 1; TSn = 1;
      @(posedge CLK40); #1;
      RESET = 0;
   endtask

   initial begin
      int t0;
      bit [7:0] offs [8];
      offs = '{8'h44, 8'h48, 8'h4A, 8'h4C, 8'h02, 8'h00, 8'h46, 8'h4E};
      repeat (2) @(posedge CLK40);
      #1 RESET = 0;
      chk("reset D_OUT", D_OUT, 4'h0);
      chk("reset CONFIG_OUTn", CONFIG_OUTn, 1'b1);
      chk("reset AC_AD", AC_AD, 8'h00);

      // Device 0 read, then non-committing and committing writes.
      t0 = n_tack;
      issue(1, 8'h02, 4'h0, 8'h42, 1, 0, 0, 1);
      chk("rd0 D_OUT", D_OUT, 4'h2);
      chk("rd0 ACTIVE_DEV", ACTIVE_DEV, 0);
      chk("rd0 tack count", n_tack - t0, 1);
      chk("rd0 AC_AD", AC_AD, 8'h02);
      seen_we = 0;
      issue(0, 8'h4A, 4'hA, 8'h42, 1, 0, 0, 1);
      chk("wr4A strobe", seen_we, 2'b01);
      chk("wr4A reg", seen_reg, 2);
      chk("wr4A data", BASE_DATA, 4'hA);
      chk("wr4A devcfg", DEV_CONFIGURED, 2'b00);
      seen_we = 0;
      issue(0, 8'h48, 4'hE, 8'h42, 1, 0, 1, 1);
      chk("wr48 strobe", seen_we, 2'b01);
      chk("wr48 devcfg", DEV_CONFIGURED, 2'b01);
      chk("wr48 ACTIVE_DEV", ACTIVE_DEV, 1);
      issue(1, 8'h02, 4'h0, 8'h42, 1, 0, 0, 1);
      chk("rd1 D_OUT", D_OUT, 4'h4);

      // Device 1 is Zorro III: 0x48 only strobes, 0x44 commits.
      seen_we = 0;
      issue(0, 8'h48, 4'h3, 8'h42, 1, 0, 0, 1);
      chk("z3 48 strobe", seen_we, 2'b10);
      chk("z3 48 devcfg", DEV_CONFIGURED, 2'b01);
      seen_we = 0;
      issue(0, 8'h44, 4'h1, 8'h42, 1, 0, 0, 1);
      chk("z3 44 reg", seen_reg, 0);
      chk("z3 CONFIGURED", CONFIGURED, 1);
      chk("z3 CONFIG_OUTn", CONFIG_OUTn, 0);
      chk("z3 D_OUT", D_OUT, 4'hF);
      t0 = n_tack;
      issue(1, 8'h02, 4'h0, 8'h42, 1, 0, 0, 3);
      chk("cfg no tack", n_tack - t0, 0);

      // Shut-up on device 0.
      do_reset();
      t0 = n_tack; seen_we = 0;
      issue(0, 8'h4C, 4'h0, 8'h42, 1, 0, 0, 1);
      chk("shutup strobe", seen_we, 2'b00);
      chk("shutup devcfg", DEV_CONFIGURED, 2'b01);
      chk("shutup ACTIVE_DEV", ACTIVE_DEV, 1);
      chk("shutup tack", n_tack - t0, 1);

      // Reset landing on the edge after TSn of a write.
      do_reset();
      t0 = n_tack; seen_we = 0;
      AUTOCONFIG_SPACE = 1; TSn = 0; RnW = 0; A = 7'h24; D_IN = 4'h5;
      @(posedge CLK40); #1;
      TSn = 1; RESET = 1;
      @(posedge CLK40); #1;
      RESET = 0;
      repeat (3) begin @(posedge CLK40); #1; end
      chk("abort tack", n_tack - t0, 0);
      chk("abort strobe", seen_we, 2'b00);
      chk("abort devcfg", DEV_CONFIGURED, 2'b00);
      issue(1, 8'h02, 4'h0, 8'h97, 1, 0, 0, 1);
      chk("abort then rd", D_OUT, 4'h7);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         if (m_cfg && $urandom_range(0, 3) == 0) do_reset();
         issue($urandom_range(0, 1) == 1,
               ($urandom_range(0, 5) == 0) ? 8'($urandom & 32'hFE) : offs[$urandom_range(0, 7)],
               4'($urandom), 8'($urandom),
               $urandom_range(0, 7) != 0,
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 2));
      end
      repeat (3) @(posedge CLK40);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
